// File: rtl/chess_pkg.sv
// Shared chess board definitions: piece codes, square/glyph colours, board geometry
// and the per-pixel colour rule used by the square painter.
package chess_pkg;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] B_PAWN   = 4'd1;
  localparam logic [3:0] B_KNIGHT = 4'd2;
  localparam logic [3:0] B_BISHOP = 4'd3;
  localparam logic [3:0] B_ROOK   = 4'd4;
  localparam logic [3:0] B_QUEEN  = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] W_PAWN   = 4'd7;
  localparam logic [3:0] W_KNIGHT = 4'd8;
  localparam logic [3:0] W_BISHOP = 4'd9;
  localparam logic [3:0] W_ROOK   = 4'd10;
  localparam logic [3:0] W_QUEEN  = 4'd11;
  localparam logic [3:0] W_KING   = 4'd12;

  localparam logic [2:0] LIGHT_SQ = 3'b111;
  localparam logic [2:0] DARK_SQ  = 3'b010;
  localparam logic [2:0] BLACK_PC = 3'b001;
  localparam logic [2:0] WHITE_PC = 3'b100;

  localparam int TILE_DEF     = 15;
  localparam int BOARD_X0_DEF = 20;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} draw_state_e;

  // Codes outside 1..12 (empty or invalid) paint only the square background.
  function automatic logic [2:0] pixel_colour(input logic [2:0] sx, input logic [2:0] sy,
                                              input int px, input int py,
                                              input logic [3:0] pc,
                                              input int tile, input int inset);
    logic glyph;
    glyph = (px >= inset) && (px <= tile - 1 - inset) &&
            (py >= inset) && (py <= tile - 1 - inset);
    if (glyph && pc >= B_PAWN && pc <= B_KING) return BLACK_PC;
    if (glyph && pc >= W_PAWN && pc <= W_KING) return WHITE_PC;
    return (sx[0] ^ sy[0]) ? DARK_SQ : LIGHT_SQ;
  endfunction

endpackage

// File: rtl/square_drawer_if.sv
// VGA adapter plot bus: one registered pixel write per strobe.
interface square_drawer_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/board_ram.sv
// 64x4 board register file: async clear, synchronous write, asynchronous read.
module board_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [5:0] wr_idx,
  input  logic [3:0] wr_data,
  input  logic [5:0] rd_idx,
  output logic [3:0] rd_data
);

  logic [3:0] mem_q [64];
  logic [3:0] mem_d [64];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/square_drawer.sv
// Stores a piece into the board memory and repaints its square, one registered
// pixel per clock in row-major order.
module square_drawer
  import chess_pkg::*;
#(
  parameter int TILE     = TILE_DEF,
  parameter int BOARD_X0 = BOARD_X0_DEF,
  parameter int INSET    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       sq_x,
  input  logic [2:0]       sq_y,
  input  logic [3:0]       piece,
  input  logic [2:0]       rd_x,
  input  logic [2:0]       rd_y,
  output logic [3:0]       rd_piece,
  output logic             busy,
  output logic             done,
  square_drawer_if.master  vga
);

  localparam int CW = $clog2(TILE);
  localparam logic [CW-1:0] LAST = CW'(TILE - 1);

  draw_state_e   state_q, state_d;
  logic [2:0]    sx_q, sx_d, sy_q, sy_d;
  logic [3:0]    pc_q, pc_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    col_q, col_d;
  logic          plot_q, plot_d;
  logic          we;

  // Pixel about to be registered onto the bus (the latched square, or the new request)
  logic [2:0]    psx, psy;
  logic [3:0]    ppc;
  logic [CW-1:0] ppx, ppy;

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    pc_d    = pc_q;
    px_d    = px_q;
    py_d    = py_q;
    plot_d  = 1'b0;
    we      = 1'b0;
    psx     = sx_q;
    psy     = sy_q;
    ppc     = pc_q;
    ppx     = px_q;
    ppy     = py_q;
    case (state_q)
      IDLE: if (start) begin
        sx_d    = sq_x;
        sy_d    = sq_y;
        pc_d    = piece;
        px_d    = '0;
        py_d    = '0;
        we      = 1'b1;
        plot_d  = 1'b1;
        psx     = sq_x;
        psy     = sq_y;
        ppc     = piece;
        ppx     = '0;
        ppy     = '0;
        state_d = DRAW;
      end
      DRAW: begin
        if (px_q == LAST && py_q == LAST) begin
          state_d = DONE;
        end else begin
          plot_d = 1'b1;
          if (px_q == LAST) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
          ppx = px_d;
          ppy = py_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    if (plot_d) begin
      x_d   = 8'(BOARD_X0) + 8'(TILE) * 8'(psx) + 8'(ppx);
      y_d   = 7'(8'(TILE) * 8'(psy) + 8'(ppy));
      col_d = pixel_colour(psx, psy, int'(ppx), int'(ppy), ppc, TILE, INSET);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      pc_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      pc_q    <= pc_d;
      px_q    <= px_d;
      py_q    <= py_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
    end
  end

  board_ram u_ram (
    .clk     (clk),
    .rst_n   (resetn),
    .we      (we),
    .wr_idx  ({sq_y, sq_x}),
    .wr_data (piece),
    .rd_idx  ({rd_y, rd_x}),
    .rd_data (rd_piece)
  );

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign vga.vga_x      = x_q;
  assign vga.vga_y      = y_q;
  assign vga.vga_colour = col_q;
  assign vga.vga_plot   = plot_q;

endmodule
